// File: rtl/clk_gate_ctrl.sv
// Per-domain clock-gating controller: each domain idles out to OFF, wakes through WAKE, and reports ready.
// Optional build macro CLK_GATE_STATS_EN adds per-domain gated-cycle counters with a synchronous clear.
module clk_gate_ctrl #(
    parameter int N_DOM       = 4,
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_gating_en,
    input  logic [N_DOM-1:0]    force_on,
    input  logic [N_DOM-1:0]    active,
    input  logic [N_DOM-1:0]    wake_req,
`ifdef CLK_GATE_STATS_EN
    input  logic                stat_clr,
    output logic [N_DOM*16-1:0] gated_cycles,
`endif
    output logic [N_DOM-1:0]    gate_en,
    output logic [N_DOM-1:0]    ready
);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_OFF  = 2'd1,
        ST_WAKE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    genvar gi;
    generate
        for (gi = 0; gi < N_DOM; gi++) begin : g_dom
            state_t           state_q, state_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             gate_q, gate_d;
            logic             rdy_q, rdy_d;
            logic             idle;

            assign idle = !active[gi] && !wake_req[gi] && !force_on[gi] && cfg_gating_en;

            // One counter serves both the idle run (ON) and the wake delay (WAKE);
            // it is cleared on every state change so it never wraps.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    ST_ON: begin
                        if (idle) begin
                            if (cnt_q == IDLE_LAST) begin
                                state_d = ST_OFF;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else begin
                            cnt_d = '0;
                        end
                    end
                    ST_OFF: begin
                        cnt_d = '0;
                        if (!idle) begin
                            state_d = ST_WAKE;
                        end
                    end
                    ST_WAKE: begin
                        if (cnt_q == WAKE_LAST) begin
                            state_d = ST_ON;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                    default: begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                    end
                endcase
                // Outputs are decoded from the next state so they can be registered glitch-free.
                gate_d = (state_d != ST_OFF);
                rdy_d  = (state_d == ST_ON);
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_q <= ST_ON;
                    cnt_q   <= '0;
                    gate_q  <= 1'b1;
                    rdy_q   <= 1'b1;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    gate_q  <= gate_d;
                    rdy_q   <= rdy_d;
                end
            end

            assign gate_en[gi] = gate_q;
            assign ready[gi]   = rdy_q;
        end
    endgenerate

`ifdef CLK_GATE_STATS_EN
    generate
        for (gi = 0; gi < N_DOM; gi++) begin : g_stat
            logic [15:0] stat_q, stat_d;

            always_comb begin
                stat_d = stat_q;
                if (stat_clr) begin
                    stat_d = '0;
                end else if (!gate_en[gi] && (stat_q != 16'hFFFF)) begin
                    stat_d = stat_q + 16'd1;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    stat_q <= '0;
                end else begin
                    stat_q <= stat_d;
                end
            end

            assign gated_cycles[16*gi +: 16] = stat_q;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Bench for clk_gate_ctrl: table of stimulus steps plus a per-cycle reference model feeding a scoreboard queue.
module tb_clk_gate_ctrl;
    localparam int N    = 4;
    localparam int IDLE = 16;
    localparam int WAKE = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         cfg;
    logic [N-1:0] force_on, active, wake_req;
    logic [N-1:0] gate_en, ready;
`ifdef CLK_GATE_STATS_EN
    logic          stat_clr;
    logic [N*16-1:0] gated_cycles;
`endif

    always #5 clk = ~clk;

    clk_gate_ctrl #(
        .N_DOM(N), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cfg_gating_en(cfg),
        .force_on(force_on),
        .active(active),
        .wake_req(wake_req),
`ifdef CLK_GATE_STATS_EN
        .stat_clr(stat_clr),
        .gated_cycles(gated_cycles),
`endif
        .gate_en(gate_en),
        .ready(ready)
    );

    typedef struct {
        logic       cfg;
        logic [3:0] frc;
        logic [3:0] act;
        logic [3:0] wak;
        int         reps;
        logic [3:0] eg;
        logic [3:0] er;
    } vec_t;

    typedef struct {
        string      name;
        logic [3:0] g;
        logic [3:0] r;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: 0 = ON, 1 = OFF, 2 = WAKE; run counts idle cycles, left counts down the wake delay.
    int m_st[N];
    int m_run[N];
    int m_left[N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_st[i] = 0; m_run[i] = 0; m_left[i] = 0;
        end
    endtask

    task automatic model_step(output logic [3:0] mg, output logic [3:0] mr);
        bit idle;
        for (int i = 0; i < N; i++) begin
            idle = !active[i] && !wake_req[i] && !force_on[i] && cfg;
            case (m_st[i])
                0: begin
                    if (idle) begin
                        m_run[i]++;
                        if (m_run[i] == IDLE) begin m_st[i] = 1; m_run[i] = 0; end
                    end else m_run[i] = 0;
                end
                1: if (!idle) begin m_st[i] = 2; m_left[i] = WAKE; end
                default: begin
                    m_left[i]--;
                    if (m_left[i] == 0) m_st[i] = 0;
                end
            endcase
            mg[i] = (m_st[i] != 1);
            mr[i] = (m_st[i] == 0);
        end
    endtask

    task automatic check(input string name, input logic [3:0] eg, input logic [3:0] er);
        total++;
        if (gate_en !== eg || ready !== er) begin
            bad++;
            $display("FAIL %s: gate_en=%h ready=%h required gate_en=%h ready=%h", name, gate_en, ready, eg, er);
        end
    endtask

    // One clock: model predicts, optional table expectation is queued, edge, then the queue is drained.
    task automatic run_cycle(input bit tab, input string tname, input logic [3:0] eg, input logic [3:0] er);
        logic [3:0] mg, mr;
        exp_t e;
        model_step(mg, mr);
        e.name = "model"; e.g = mg; e.r = mr;
        sb.push_back(e);
        if (tab) begin
            e.name = tname; e.g = eg; e.r = er;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.name, e.g, e.r);
        end
    endtask

`ifdef CLK_GATE_STATS_EN
    task automatic check_stat(input string name, input logic [15:0] exp_v);
        total++;
        if (gated_cycles[63:48] !== exp_v) begin
            bad++;
            $display("FAIL %s: gated_cycles[3]=%0d required %0d", name, gated_cycles[63:48], exp_v);
        end
    endtask
`endif

    vec_t vecs[24];

    initial begin
        vecs[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 15, 4'hF, 4'hF};
        vecs[1]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1,  4'h0, 4'h0};
        vecs[2]  = '{1'b1, 4'h0, 4'h0, 4'h1, 1,  4'h1, 4'h0};
        vecs[3]  = '{1'b1, 4'h0, 4'h0, 4'h1, 1,  4'h1, 4'h0};
        vecs[4]  = '{1'b1, 4'h0, 4'h0, 4'h1, 1,  4'h1, 4'h1};
        vecs[5]  = '{1'b1, 4'h0, 4'h0, 4'h0, 15, 4'h1, 4'h1};
        vecs[6]  = '{1'b1, 4'h0, 4'h0, 4'h0, 1,  4'h0, 4'h0};
        vecs[7]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1,  4'hF, 4'h0};
        vecs[8]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1,  4'hF, 4'h0};
        vecs[9]  = '{1'b0, 4'h0, 4'h0, 4'h0, 1,  4'hF, 4'hF};
        vecs[10] = '{1'b0, 4'h0, 4'h0, 4'h0, 100, 4'hF, 4'hF};
        vecs[11] = '{1'b1, 4'h0, 4'h0, 4'h0, 15, 4'hF, 4'hF};
        vecs[12] = '{1'b1, 4'h0, 4'h4, 4'h0, 1,  4'h4, 4'h4};
        vecs[13] = '{1'b1, 4'h0, 4'h0, 4'h0, 15, 4'h4, 4'h4};
        vecs[14] = '{1'b1, 4'h0, 4'h0, 4'h0, 1,  4'h0, 4'h0};
        vecs[15] = '{1'b0, 4'h0, 4'h0, 4'h0, 3,  4'hF, 4'hF};
        vecs[16] = '{1'b1, 4'h2, 4'h0, 4'h0, 15, 4'hF, 4'hF};
        vecs[17] = '{1'b1, 4'h2, 4'h0, 4'h0, 1,  4'h2, 4'h2};
        vecs[18] = '{1'b1, 4'h2, 4'h0, 4'h0, 20, 4'h2, 4'h2};
        vecs[19] = '{1'b1, 4'h2, 4'h0, 4'h1, 1,  4'h3, 4'h2};
        vecs[20] = '{1'b1, 4'h2, 4'h0, 4'h0, 1,  4'h3, 4'h2};
        vecs[21] = '{1'b1, 4'h2, 4'h0, 4'h0, 1,  4'h3, 4'h3};
        vecs[22] = '{1'b1, 4'h2, 4'h0, 4'h0, 15, 4'h3, 4'h3};
        vecs[23] = '{1'b1, 4'h2, 4'h0, 4'h0, 1,  4'h2, 4'h2};

        reset = 1'b1; cfg = 1'b1; force_on = '0; active = '0; wake_req = '0;
`ifdef CLK_GATE_STATS_EN
        stat_clr = 1'b0;
`endif
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 4'hF, 4'hF);
        reset = 1'b0;

        for (int v = 0; v < 24; v++) begin
            cfg = vecs[v].cfg; force_on = vecs[v].frc;
            active = vecs[v].act; wake_req = vecs[v].wak;
            for (int k = 0; k < vecs[v].reps; k++) begin
                run_cycle(k == vecs[v].reps - 1, $sformatf("vec%0d", v), vecs[v].eg, vecs[v].er);
            end
        end

        // Domain 3 starts waking while domain 0 sits OFF, then an asynchronous reset lands mid-cycle.
        wake_req = 4'h8;
        run_cycle(1'b1, "wake_dom3", 4'hA, 4'h2);
        wake_req = 4'h0;
        #2 reset = 1'b1;
        #1;
        check("async_reset", 4'hF, 4'hF);
        @(posedge clk);
        #1;
        check("reset_held", 4'hF, 4'hF);
        reset = 1'b0; force_on = '0;
        model_reset();
        run_cycle(1'b1, "post_reset", 4'hF, 4'hF);

`ifdef CLK_GATE_STATS_EN
        for (int k = 0; k < 15; k++) run_cycle(1'b0, "", 4'h0, 4'h0);
        check_stat("stat_before_off", 16'd0);
        for (int k = 0; k < 40; k++) run_cycle(1'b0, "", 4'h0, 4'h0);
        check_stat("stat_40", 16'd40);
        stat_clr = 1'b1;
        run_cycle(1'b0, "", 4'h0, 4'h0);
        check_stat("stat_clr", 16'd0);
        stat_clr = 1'b0;
        for (int k = 0; k < 65600; k++) begin
            @(posedge clk);
        end
        #1;
        check_stat("stat_sat", 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
